pc_stack: RTL and testbench

Parametrised program counter with conditional relative branches, absolute jumps, and a hardware return-address stack (RAS) for CALL/RET. It sits in the fetch stage. It takes the decoded branch opcode and immediate from the control unit and the ZF/CF flags from the ALU, and it drives the instruction-memory address. It supersedes the fixed 10-bit PC by generalising width and adding subroutine support with overflow/underflow detection.

---
 rtl/pc_stack_if.sv | 30 +++
 rtl/pc_stack.sv | 153 +++++++++++++++
 tb/tb_pc_stack.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// pc_stack_if: control/flag inputs and PC/RAS status outputs of pc_stack.
// The master drives the decoded op and flags; the slave (pc_stack) drives status.
interface pc_stack_if #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                enable;
  logic [3:0]          op;
  logic [PC_WIDTH-1:0] immediate;
  logic                ZF;
  logic                CF;
  logic [PC_WIDTH-1:0] pc_value;
  logic [PC_WIDTH-1:0] ret_addr;
  logic [DEPTH_W-1:0]  depth;
  logic                overflow;
  logic                underflow;
  logic                fault;

  modport master (
    output enable, op, immediate, ZF, CF,
    input  pc_value, ret_addr, depth, overflow, underflow, fault
  );

  modport slave (
    input  enable, op, immediate, ZF, CF,
    output pc_value, ret_addr, depth, overflow, underflow, fault
  );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: fetch-stage program counter with conditional relative branches,
// absolute jumps and a return-address stack for CALL/RET.
// The RAS is built only when the macro PC_RAS_EN is defined; otherwise
// CALL/RET hold the PC and all stack status outputs are tied to zero.
module pc_stack #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input logic       clock,
  input logic       reset,
  pc_stack_if.slave bus
);

  typedef enum logic [3:0] {
    OP_RST  = 4'd0,
    OP_JMP  = 4'd1,
    OP_JE   = 4'd2,
    OP_JA   = 4'd3,
    OP_JB   = 4'd4,
    OP_JAE  = 4'd5,
    OP_JBE  = 4'd6,
    OP_INC  = 4'd7,
    OP_CALL = 4'd8,
    OP_RET  = 4'd9,
    OP_JABS = 4'd10
  } op_e;

  localparam int unsigned         DW = $clog2(STACK_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] RV = PC_WIDTH'(RESET_VECTOR);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt, nxt;
  logic                zf, cf;

  assign zf  = bus.ZF;
  assign cf  = bus.CF;
  // Operands share PC_WIDTH, so a plain modular add already treats the
  // immediate as a sign-extended two's complement offset.
  assign tgt = pc_q + bus.immediate;
  assign nxt = pc_q + PC_WIDTH'(1);

`ifdef PC_RAS_EN
  localparam int unsigned   AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                fault_q, fault_d;
  logic [AW-1:0]       wr_idx, rd_idx;

  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - DW'(1));
`endif

  // Next-PC selection and stack push/pop decision for the current op.
  always_comb begin
    pc_d = pc_q;
`ifdef PC_RAS_EN
    stack_d     = stack_q;
    depth_d     = depth_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    fault_d     = fault_q;
`endif
    if (bus.enable) begin
      case (bus.op)
        OP_RST:  pc_d = RV;
        OP_JMP:  pc_d = tgt;
        OP_JE:   pc_d = (zf && !cf)  ? tgt : nxt;
        OP_JA:   pc_d = (!zf && !cf) ? tgt : nxt;
        OP_JB:   pc_d = (!zf && cf)  ? tgt : nxt;
        OP_JAE:  pc_d = (!cf)        ? tgt : nxt;
        OP_JBE:  pc_d = (zf || cf)   ? tgt : nxt;
        OP_INC:  pc_d = nxt;
        OP_JABS: pc_d = bus.immediate;
`ifdef PC_RAS_EN
        OP_CALL: begin
          if (depth_q == FULL) begin
            overflow_d = 1'b1;
            fault_d    = 1'b1;
          end else begin
            stack_d[wr_idx] = nxt;
            depth_d         = depth_q + DW'(1);
            pc_d            = tgt;
          end
        end
        OP_RET: begin
          if (depth_q == '0) begin
            underflow_d = 1'b1;
            fault_d     = 1'b1;
          end else begin
            pc_d    = stack_q[rd_idx];
            depth_d = depth_q - DW'(1);
          end
        end
`endif
        default: pc_d = pc_q;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RV;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_value = pc_q;

`ifdef PC_RAS_EN
  // Stack storage, occupancy and error status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.ret_addr  = (depth_q == '0) ? '0 : stack_q[rd_idx];
  assign bus.depth     = depth_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.fault     = fault_q;
`else
  logic [DW-1:0] depth_tie;

  assign depth_tie     = '0;
  assign bus.ret_addr  = '0;
  assign bus.depth     = depth_tie;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: table-driven and sequence checks of pc_stack with a
// scoreboard queue of expected post-edge outputs.
module tb_pc_stack;

  localparam int unsigned PW = 10;
  localparam int unsigned SD = 4;

  typedef struct {
    logic [PW-1:0] pc;
    logic [2:0]    depth;
    logic [PW-1:0] ret;
    logic          ovf;
    logic          unf;
    logic          flt;
  } exp_t;

  typedef struct {
    logic [3:0]    op;
    logic          zf;
    logic          cf;
    logic [PW-1:0] exp_pc;
  } vec_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[22];

  pc_stack_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus ();

  pc_stack #(
    .PC_WIDTH    (PW),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [PW-1:0] pc, input logic [2:0] d,
                              input logic [PW-1:0] r, input logic o, input logic u,
                              input logic f);
    exp_t e;
    e.pc = pc; e.depth = d; e.ret = r; e.ovf = o; e.unf = u; e.flt = f;
    return e;
  endfunction

  // Drive one op for the next rising edge and queue what must follow it.
  task automatic apply(input logic en, input logic [3:0] op, input logic [PW-1:0] imm,
                       input logic zf, input logic cf, input exp_t e);
    @(negedge clock);
    bus.enable    = en;
    bus.op        = op;
    bus.immediate = imm;
    bus.ZF        = zf;
    bus.CF        = cf;
    sb.push_back(e);
  endtask

  // Compare DUT outputs shortly after each edge that consumed a queued op.
  always @(posedge clock) begin
    #2;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("pc_value",  32'(bus.pc_value),  32'(mon_e.pc));
      check("depth",     32'(bus.depth),     32'(mon_e.depth));
      check("ret_addr",  32'(bus.ret_addr),  32'(mon_e.ret));
      check("overflow",  32'(bus.overflow),  32'(mon_e.ovf));
      check("underflow", 32'(bus.underflow), 32'(mon_e.unf));
      check("fault",     32'(bus.fault),     32'(mon_e.flt));
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tbl = '{
      '{4'd2, 1'b0, 1'b0, 10'd21}, '{4'd2, 1'b0, 1'b1, 10'd21},
      '{4'd2, 1'b1, 1'b0, 10'd25}, '{4'd2, 1'b1, 1'b1, 10'd21},
      '{4'd3, 1'b0, 1'b0, 10'd25}, '{4'd3, 1'b0, 1'b1, 10'd21},
      '{4'd3, 1'b1, 1'b0, 10'd21}, '{4'd3, 1'b1, 1'b1, 10'd21},
      '{4'd4, 1'b0, 1'b0, 10'd21}, '{4'd4, 1'b0, 1'b1, 10'd25},
      '{4'd4, 1'b1, 1'b0, 10'd21}, '{4'd4, 1'b1, 1'b1, 10'd21},
      '{4'd5, 1'b0, 1'b0, 10'd25}, '{4'd5, 1'b0, 1'b1, 10'd21},
      '{4'd5, 1'b1, 1'b0, 10'd25}, '{4'd5, 1'b1, 1'b1, 10'd21},
      '{4'd6, 1'b0, 1'b0, 10'd21}, '{4'd6, 1'b0, 1'b1, 10'd25},
      '{4'd6, 1'b1, 1'b0, 10'd25}, '{4'd6, 1'b1, 1'b1, 10'd25},
      '{4'd11, 1'b0, 1'b0, 10'd20}, '{4'd15, 1'b1, 1'b1, 10'd20}
    };

    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.op        = 4'd0;
    bus.immediate = '0;
    bus.ZF        = 1'b0;
    bus.CF        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_pc",    32'(bus.pc_value), 32'd0);
    check("reset_depth", 32'(bus.depth),    32'd0);
    check("reset_fault", 32'(bus.fault),    32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Jumps and wrap-around.
    apply(1'b1, 4'd1,  10'd10,   1'b0, 1'b0, mk(10'd10,   3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd1,  10'h3FD,  1'b0, 1'b0, mk(10'd7,    3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd10, 10'd1023, 1'b0, 1'b0, mk(10'd1023, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd7,  10'd99,   1'b0, 1'b0, mk(10'd0,    3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd10, 10'd500,  1'b0, 1'b0, mk(10'd500,  3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd0,  10'd77,   1'b1, 1'b1, mk(10'd0,    3'd0, 10'd0, 1'b0, 1'b0, 1'b0));

    // Conditional matrix from pc=20 with imm=5, plus reserved-op holds.
    for (int i = 0; i < 22; i++) begin
      apply(1'b1, 4'd10, 10'd20, 1'b0, 1'b0, mk(10'd20, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
      apply(1'b1, tbl[i].op, 10'd5, tbl[i].zf, tbl[i].cf,
            mk(tbl[i].exp_pc, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    end

`ifdef PC_RAS_EN
    // Nested call/return, back-to-back CALL then RET.
    apply(1'b1, 4'd10, 10'd100, 1'b0, 1'b0, mk(10'd100, 3'd0, 10'd0,   1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd8,  10'd50,  1'b0, 1'b0, mk(10'd150, 3'd1, 10'd101, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd8,  10'd10,  1'b0, 1'b0, mk(10'd160, 3'd2, 10'd151, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd9,  10'd0,   1'b0, 1'b0, mk(10'd151, 3'd1, 10'd101, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd9,  10'd0,   1'b0, 1'b0, mk(10'd101, 3'd0, 10'd0,   1'b0, 1'b0, 1'b0));
    // Underflow, then stall with a pending JMP.
    apply(1'b1, 4'd9,  10'd0,   1'b0, 1'b0, mk(10'd101, 3'd0, 10'd0,   1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++)
      apply(1'b0, 4'd1, 10'd7, 1'b0, 1'b0, mk(10'd101, 3'd0, 10'd0, 1'b0, 1'b0, 1'b1));
    // Fill the stack, overflow, stall, RST keeps RAS, then drain it.
    apply(1'b1, 4'd8, 10'd1, 1'b0, 1'b0, mk(10'd102, 3'd1, 10'd102, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd8, 10'd1, 1'b0, 1'b0, mk(10'd103, 3'd2, 10'd103, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd8, 10'd1, 1'b0, 1'b0, mk(10'd104, 3'd3, 10'd104, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd8, 10'd1, 1'b0, 1'b0, mk(10'd105, 3'd4, 10'd105, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd8, 10'd1, 1'b0, 1'b0, mk(10'd105, 3'd4, 10'd105, 1'b1, 1'b0, 1'b1));
    apply(1'b0, 4'd8, 10'd1, 1'b0, 1'b0, mk(10'd105, 3'd4, 10'd105, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd0, 10'd0, 1'b0, 1'b0, mk(10'd0,   3'd4, 10'd105, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd9, 10'd0, 1'b0, 1'b0, mk(10'd105, 3'd3, 10'd104, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd9, 10'd0, 1'b0, 1'b0, mk(10'd104, 3'd2, 10'd103, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd9, 10'd0, 1'b0, 1'b0, mk(10'd103, 3'd1, 10'd102, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 4'd9, 10'd0, 1'b0, 1'b0, mk(10'd102, 3'd0, 10'd0,   1'b0, 1'b0, 1'b1));
`else
    // Without the RAS, CALL and RET behave as hold.
    apply(1'b1, 4'd10, 10'd100, 1'b0, 1'b0, mk(10'd100, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd8,  10'd50,  1'b0, 1'b0, mk(10'd100, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd9,  10'd0,   1'b0, 1'b0, mk(10'd100, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd9,  10'd0,   1'b0, 1'b0, mk(10'd100, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      apply(1'b0, 4'd1, 10'd7, 1'b0, 1'b0, mk(10'd100, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 4'd7,  10'd0,   1'b0, 1'b0, mk(10'd101, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
`endif

    // Asynchronous reset in the middle of a cycle, no edge needed.
    apply(1'b1, 4'd10, 10'd300, 1'b0, 1'b0, mk(10'd300, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_pc",    32'(bus.pc_value),  32'd0);
    check("async_depth", 32'(bus.depth),     32'd0);
    check("async_ret",   32'(bus.ret_addr),  32'd0);
    check("async_unf",   32'(bus.underflow), 32'd0);
    check("async_fault", 32'(bus.fault),     32'd0);
    @(negedge clock);
    bus.enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    apply(1'b1, 4'd1, 10'd10, 1'b0, 1'b0, mk(10'd10, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0));

    @(negedge clock);
    bus.enable = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
